// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: bundles the fetch requester, data requester and physical SRAM
// signals shared by sram_port_arbiter.
//   master modport - environment side (drives requests and SRAM read data)
//   slave modport  - arbiter side (drives grants, return data and the SRAM command)
interface sram_port_arbiter_if;
    // Fetch requester
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    // Data requester
    logic        dm_req;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    // Physical SRAM
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, sram_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, sram_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported, 1-cycle-latency synchronous SRAM between an
// instruction-fetch requester and a data requester. Data has priority; a saturating starvation
// counter forces a fetch grant after STARVE_MAX consecutive lost conflicts.
// Ports:
//   clk          - clock, rising edge
//   resetn       - asynchronous active-low reset
//   bus          - requester/SRAM bundle (slave modport)
//   conflict_cnt - count of cycles with both requests high (wraps)
module sram_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                resetn,
    sram_port_arbiter_if.slave  bus,
    output logic [31:0]         conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2
    } owner_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    owner_e     owner;
    logic [3:0] starve;
    logic       if_win;
    logic       dm_win;

    // Grants are masked by resetn so nothing reaches the SRAM while reset is held.
    always_comb begin
        if_win = 1'b0;
        dm_win = 1'b0;
        if (resetn) begin
            if (bus.if_req && bus.dm_req) begin
                if (starve == StarveMax) begin
                    if_win = 1'b1;
                end else begin
                    dm_win = 1'b1;
                end
            end else begin
                if_win = bus.if_req;
                dm_win = bus.dm_req;
            end
        end
    end

    assign bus.if_gnt = if_win;
    assign bus.dm_gnt = dm_win;

    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'b0000;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
        if (if_win) begin
            bus.sram_en   = 1'b1;
            bus.sram_addr = bus.if_addr;
        end else if (dm_win) begin
            bus.sram_en    = 1'b1;
            bus.sram_wen   = bus.dm_wen;
            bus.sram_addr  = bus.dm_addr;
            bus.sram_wdata = bus.dm_wdata;
        end
    end

    // owner records who issued last cycle's read; it steers the returning SRAM data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner        <= IDLE;
            starve       <= 4'd0;
            conflict_cnt <= 32'h0;
        end else begin
            if (if_win) begin
                owner <= RD_IF;
            end else if (dm_win && (bus.dm_wen == 4'b0000)) begin
                owner <= RD_DM;
            end else begin
                owner <= IDLE;
            end

            if (if_win || !bus.if_req) begin
                starve <= 4'd0;
            end else if (dm_win && (starve != StarveMax)) begin
                starve <= starve + 4'd1;
            end

            if (bus.if_req && bus.dm_req) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end

    assign bus.if_rvalid = (owner == RD_IF);
    assign bus.dm_rvalid = (owner == RD_DM);
    assign bus.if_rdata  = bus.if_rvalid ? bus.sram_rdata : 32'h0;
    assign bus.dm_rdata  = bus.dm_rvalid ? bus.sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench for sram_port_arbiter. dut0 uses STARVE_MAX=4,
// dut1 uses STARVE_MAX=0. Inputs change on the falling edge; outputs are sampled 1 ns later
// or 1 ns after the rising edge.
module tb_sram_port_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] cnt0;
    logic [31:0] cnt1;
    int          checks;
    int          failures;

    sram_port_arbiter_if bus0 ();
    sram_port_arbiter_if bus1 ();

    sram_port_arbiter #(.STARVE_MAX(4)) dut0 (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus0.slave),
        .conflict_cnt (cnt0)
    );

    sram_port_arbiter #(.STARVE_MAX(0)) dut1 (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus1.slave),
        .conflict_cnt (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        bus0.if_req  = 1'b1;
        bus0.dm_req  = 1'b1;
        bus0.if_addr = 32'h0000_0040;
        bus0.dm_addr = 32'h0000_0080;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus0.if_gnt, bus0.dm_gnt, bus0.sram_en} !== 3'b000) begin
                failures++;
                $display("FAIL reset_gnt cycle %0d: got if/dm/en=%b%b%b want 000", c,
                         bus0.if_gnt, bus0.dm_gnt, bus0.sram_en);
            end
            checks++;
            if ({bus0.sram_wen, bus0.sram_addr, bus0.sram_wdata} !== 68'h0) begin
                failures++;
                $display("FAIL reset_sram_bus cycle %0d: got wen=%h addr=%h wdata=%h want 0", c,
                         bus0.sram_wen, bus0.sram_addr, bus0.sram_wdata);
            end
            checks++;
            if ({bus0.if_rvalid, bus0.dm_rvalid} !== 2'b00 ||
                {bus0.if_rdata, bus0.dm_rdata} !== 64'h0) begin
                failures++;
                $display("FAIL reset_rvalid cycle %0d: got if=%b dm=%b want 0", c,
                         bus0.if_rvalid, bus0.dm_rvalid);
            end
            checks++;
            if (cnt0 !== 32'd0) begin
                failures++;
                $display("FAIL reset_conflict_cnt: got %0d want 0", cnt0);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cnt0 !== 32'(c)) begin
                failures++;
                $display("FAIL conflict_cnt_after_release: got %0d want %0d", cnt0, c);
            end
        end
        @(negedge clk);
        bus0.if_req = 1'b0;
        bus0.dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_solo_fetch();
        @(negedge clk);
        bus0.if_req  = 1'b1;
        bus0.if_addr = 32'hBFC0_0000;
        bus0.dm_req  = 1'b0;
        #1;
        checks++;
        if ({bus0.if_gnt, bus0.dm_gnt, bus0.sram_en} !== 3'b101 ||
            bus0.sram_addr !== 32'hBFC0_0000 || bus0.sram_wen !== 4'b0000) begin
            failures++;
            $display("FAIL solo_fetch_grant: got if/dm/en=%b%b%b addr=%h wen=%b want 101 bfc00000 0000",
                     bus0.if_gnt, bus0.dm_gnt, bus0.sram_en, bus0.sram_addr, bus0.sram_wen);
        end
        @(posedge clk);
        #1;
        bus0.if_req     = 1'b0;
        bus0.sram_rdata = 32'h2408_0001;
        #1;
        checks++;
        if (bus0.if_rvalid !== 1'b1 || bus0.if_rdata !== 32'h2408_0001) begin
            failures++;
            $display("FAIL solo_fetch_rdata: got rvalid=%b rdata=%h want 1 24080001",
                     bus0.if_rvalid, bus0.if_rdata);
        end
        checks++;
        if (bus0.dm_rvalid !== 1'b0 || bus0.dm_rdata !== 32'h0) begin
            failures++;
            $display("FAIL solo_fetch_dm_quiet: got dm_rvalid=%b dm_rdata=%h want 0 0",
                     bus0.dm_rvalid, bus0.dm_rdata);
        end
        @(negedge clk);
        bus0.sram_rdata = 32'h0;
    endtask

    task automatic test_starvation();
        logic exp_if;
        logic exp_ifv;
        logic exp_dmv;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            bus0.if_req     = (c <= 8);
            bus0.dm_req     = (c <= 8);
            bus0.dm_wen     = 4'b0000;
            bus0.if_addr    = 32'h0000_1000;
            bus0.dm_addr    = 32'h0000_2000;
            bus0.sram_rdata = 32'hA000_0000 + 32'(c);
            exp_if  = (c == 4);
            exp_ifv = (c == 5);
            exp_dmv = (c > 0) && (c != 5);
            #1;
            if (c <= 8) begin
                checks++;
                if (bus0.if_gnt !== exp_if || bus0.dm_gnt !== !exp_if) begin
                    failures++;
                    $display("FAIL starve_grant cycle %0d: got if=%b dm=%b want if=%b dm=%b", c,
                             bus0.if_gnt, bus0.dm_gnt, exp_if, !exp_if);
                end
            end
            checks++;
            if (bus0.if_rvalid !== exp_ifv || bus0.dm_rvalid !== exp_dmv) begin
                failures++;
                $display("FAIL starve_rvalid cycle %0d: got if=%b dm=%b want if=%b dm=%b", c,
                         bus0.if_rvalid, bus0.dm_rvalid, exp_ifv, exp_dmv);
            end
            checks++;
            if (bus0.if_rdata !== (exp_ifv ? 32'hA000_0000 + 32'(c) : 32'h0) ||
                bus0.dm_rdata !== (exp_dmv ? 32'hA000_0000 + 32'(c) : 32'h0)) begin
                failures++;
                $display("FAIL starve_rdata cycle %0d: got if=%h dm=%h", c,
                         bus0.if_rdata, bus0.dm_rdata);
            end
        end
        bus0.sram_rdata = 32'h0;
    endtask

    task automatic test_data_write();
        @(negedge clk);
        bus0.dm_req   = 1'b1;
        bus0.dm_wen   = 4'b0011;
        bus0.dm_addr  = 32'h0000_0100;
        bus0.dm_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus0.dm_gnt !== 1'b1 || bus0.sram_en !== 1'b1 || bus0.sram_wen !== 4'b0011 ||
            bus0.sram_addr !== 32'h0000_0100 || bus0.sram_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL data_write_drive: got gnt=%b en=%b wen=%b addr=%h wdata=%h want 1 1 0011 00000100 deadbeef",
                     bus0.dm_gnt, bus0.sram_en, bus0.sram_wen, bus0.sram_addr, bus0.sram_wdata);
        end
        @(negedge clk);
        bus0.dm_req   = 1'b0;
        bus0.dm_wen   = 4'b0000;
        bus0.dm_wdata = 32'h0;
        #1;
        checks++;
        if (bus0.dm_rvalid !== 1'b0 || bus0.if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL data_write_no_rvalid: got dm=%b if=%b want 0 0",
                     bus0.dm_rvalid, bus0.if_rvalid);
        end
        checks++;
        if (bus0.sram_en !== 1'b0 || bus0.sram_wen !== 4'b0000) begin
            failures++;
            $display("FAIL idle_sram: got en=%b wen=%b want 0 0000", bus0.sram_en, bus0.sram_wen);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        bus0.dm_req  = 1'b1;
        bus0.dm_wen  = 4'b0000;
        bus0.dm_addr = 32'h0000_0200;
        #1;
        checks++;
        if (bus0.dm_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midread_grant: got dm_gnt=%b want 1", bus0.dm_gnt);
        end
        @(posedge clk);
        #1;
        bus0.dm_req = 1'b0;
        checks++;
        if (bus0.dm_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL midread_pending: got dm_rvalid=%b want 1", bus0.dm_rvalid);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (bus0.dm_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midread_during_reset: got dm_rvalid=%b want 0", bus0.dm_rvalid);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus0.dm_rvalid !== 1'b0 || bus0.if_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL midread_after_reset %0d: got dm=%b if=%b want 0 0", c,
                         bus0.dm_rvalid, bus0.if_rvalid);
            end
        end
    endtask

    task automatic test_starve_zero();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus1.if_req  = 1'b1;
            bus1.dm_req  = 1'b1;
            bus1.dm_wen  = 4'b0000;
            bus1.if_addr = 32'h0000_0300;
            bus1.dm_addr = 32'h0000_0400;
            #1;
            checks++;
            if (bus1.if_gnt !== 1'b1 || bus1.dm_gnt !== 1'b0 ||
                bus1.sram_addr !== 32'h0000_0300) begin
                failures++;
                $display("FAIL starve0_grant cycle %0d: got if=%b dm=%b addr=%h want 1 0 00000300",
                         c, bus1.if_gnt, bus1.dm_gnt, bus1.sram_addr);
            end
        end
        @(negedge clk);
        bus1.if_req = 1'b0;
        bus1.dm_req = 1'b0;
        #1;
        checks++;
        if (bus1.if_rvalid !== 1'b1 || bus1.dm_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL starve0_rvalid: got if=%b dm=%b want 1 0", bus1.if_rvalid,
                     bus1.dm_rvalid);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        resetn          = 1'b0;
        bus0.if_req     = 1'b0;
        bus0.if_addr    = 32'h0;
        bus0.dm_req     = 1'b0;
        bus0.dm_wen     = 4'b0000;
        bus0.dm_addr    = 32'h0;
        bus0.dm_wdata   = 32'h0;
        bus0.sram_rdata = 32'h0;
        bus1.if_req     = 1'b0;
        bus1.if_addr    = 32'h0;
        bus1.dm_req     = 1'b0;
        bus1.dm_wen     = 4'b0000;
        bus1.dm_addr    = 32'h0;
        bus1.dm_wdata   = 32'h0;
        bus1.sram_rdata = 32'h0;

        test_reset();
        test_solo_fetch();
        test_starvation();
        test_data_write();
        test_reset_mid_read();
        test_starve_zero();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
